// File: rtl/pkt_rx_responder.sv
// pkt_rx_responder: terminates a sop/eop/data packet bus. Incoming beats are
// buffered in a first-word-fall-through FIFO and forwarded on a ready/valid
// port. Each closed packet produces a status word and a one-cycle pulse.
//
// Ports
//   pclk, prst          clock (rising edge), synchronous active-high reset
//   sop, eop, data      input beat, qualified by rdy
//   rdy                 responder can take a beat this cycle
//   status              {seq[7:0], 6'b0, trunc, err_sop, len[15:0]}, zero-extended
//   status_valid        one-cycle pulse when status is updated
//   out_valid/out_ready FIFO head handshake
//   out_data/sop/eop    FIFO head payload and packet markers
//   pkt_count           packets closed since reset, wraps
module pkt_rx_responder #(
  parameter int unsigned DATA_WIDTH   = 240,
  parameter int unsigned STATUS_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned FULL_MARGIN  = 0,
  parameter int unsigned MAX_LEN      = 1024
) (
  input  logic                    pclk,
  input  logic                    prst,
  input  logic                    sop,
  input  logic                    eop,
  input  logic [DATA_WIDTH-1:0]   data,
  output logic                    rdy,
  output logic [STATUS_WIDTH-1:0] status,
  output logic                    status_valid,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_sop,
  output logic                    out_eop,
  output logic [15:0]             pkt_count
);

  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned ENT_W     = DATA_WIDTH + 2;
  localparam int unsigned RDY_LIMIT = FIFO_DEPTH - 1 - FULL_MARGIN;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic             rdy_q, rdy_d;

  logic [15:0]      len_q, len_d;
  logic             err_sop_q, err_sop_d;
  logic             trunc_q, trunc_d;
  logic [7:0]       seq_q;
  logic [15:0]      pkt_count_q;
  logic [31:0]      status_q, status_d;
  logic             status_valid_q;

  logic             push_c, pop_c, close_c, wr_sop_c, wr_eop_c;
  logic [ENT_W-1:0] head_c;

  assign pop_c = out_valid_q & out_ready;

  // Packet FSM: decides what to write, packet bookkeeping and close events
  always_comb begin
    state_d   = state_q;
    push_c    = 1'b0;
    wr_sop_c  = 1'b0;
    wr_eop_c  = 1'b0;
    close_c   = 1'b0;
    len_d     = len_q;
    err_sop_d = err_sop_q;
    trunc_d   = trunc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rdy_q && sop) begin
          push_c    = 1'b1;
          wr_sop_c  = 1'b1;
          len_d     = 16'd1;
          err_sop_d = 1'b0;
          trunc_d   = 1'b0;
          if (eop) begin
            wr_eop_c = 1'b1;
            close_c  = 1'b1;
          end else if (len_d == 16'(MAX_LEN)) begin
            // first beat already hits the length limit
            wr_eop_c = 1'b1;
            trunc_d  = 1'b1;
            state_d  = ST_DROP;
          end else begin
            state_d = ST_PKT;
          end
        end
      end
      ST_PKT: begin
        if (rdy_q) begin
          push_c = 1'b1;
          len_d  = len_q + 16'd1;
          if (sop) err_sop_d = 1'b1;
          if (eop) begin
            wr_eop_c = 1'b1;
            close_c  = 1'b1;
            state_d  = ST_IDLE;
          end else if (len_d == 16'(MAX_LEN)) begin
            // terminate the forwarded packet here, swallow the rest
            wr_eop_c = 1'b1;
            trunc_d  = 1'b1;
            state_d  = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (rdy_q && eop) begin
          close_c = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Occupancy, flow control and status word for the next cycle
  always_comb begin
    count_d = count_q;
    if (push_c && !pop_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_c && pop_c) begin
      count_d = count_q - CNT_W'(1);
    end
    out_valid_d = (count_d != '0);
    // rdy only rises when a full beat of headroom is left, so no overflow
    rdy_d    = (state_d == ST_DROP) || (count_d <= CNT_W'(RDY_LIMIT));
    status_d = {seq_q, 6'd0, trunc_d, err_sop_d, len_d};
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q        <= ST_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      out_valid_q    <= 1'b0;
      rdy_q          <= 1'b0;
      len_q          <= '0;
      err_sop_q      <= 1'b0;
      trunc_q        <= 1'b0;
      seq_q          <= '0;
      pkt_count_q    <= '0;
      status_q       <= '0;
      status_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      out_valid_q    <= out_valid_d;
      rdy_q          <= rdy_d;
      len_q          <= len_d;
      err_sop_q      <= err_sop_d;
      trunc_q        <= trunc_d;
      status_valid_q <= close_c;
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (close_c) begin
        status_q    <= status_d;
        seq_q       <= seq_q + 8'd1;
        pkt_count_q <= pkt_count_q + 16'd1;
      end
    end
  end

  // Beat storage, no reset needed: validity is tracked by count_q
  always_ff @(posedge pclk) begin
    if (push_c && !prst) begin
      mem_q[wr_ptr_q] <= {wr_sop_c, wr_eop_c, data};
    end
  end

  assign head_c       = mem_q[rd_ptr_q];
  assign out_data     = head_c[DATA_WIDTH-1:0];
  assign out_eop      = head_c[DATA_WIDTH];
  assign out_sop      = head_c[DATA_WIDTH+1];
  assign out_valid    = out_valid_q;
  assign rdy          = rdy_q;
  assign status       = STATUS_WIDTH'(status_q);
  assign status_valid = status_valid_q;
  assign pkt_count    = pkt_count_q;

endmodule

// File: tb/tb_pkt_rx_responder.sv
// Testbench for pkt_rx_responder: two instances (long MAX_LEN / deep FIFO, and
// short MAX_LEN / shallow FIFO with margin) share stimulus; a queue-based
// packet model predicts every output each cycle.
module tb_pkt_rx_responder;

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 40;

  logic          pclk = 1'b0;
  logic          prst, sop, eop, out_ready;
  logic [DW-1:0] data;

  logic          rdy_a, sv_a, ov_a, os_a, oe_a;
  logic [SW-1:0] st_a;
  logic [DW-1:0] od_a;
  logic [15:0]   pc_a;
  logic          rdy_b, sv_b, ov_b, os_b, oe_b;
  logic [SW-1:0] st_b;
  logic [DW-1:0] od_b;
  logic [15:0]   pc_b;

  always #5 pclk = ~pclk;

  pkt_rx_responder #(.DATA_WIDTH(DW), .STATUS_WIDTH(SW), .FIFO_DEPTH(16),
                     .FULL_MARGIN(0), .MAX_LEN(1024)) u_dut_a (
    .pclk(pclk), .prst(prst), .sop(sop), .eop(eop), .data(data), .rdy(rdy_a),
    .status(st_a), .status_valid(sv_a), .out_valid(ov_a), .out_ready(out_ready),
    .out_data(od_a), .out_sop(os_a), .out_eop(oe_a), .pkt_count(pc_a));

  pkt_rx_responder #(.DATA_WIDTH(DW), .STATUS_WIDTH(SW), .FIFO_DEPTH(8),
                     .FULL_MARGIN(2), .MAX_LEN(8)) u_dut_b (
    .pclk(pclk), .prst(prst), .sop(sop), .eop(eop), .data(data), .rdy(rdy_b),
    .status(st_b), .status_valid(sv_b), .out_valid(ov_b), .out_ready(out_ready),
    .out_data(od_b), .out_sop(os_b), .out_eop(oe_b), .pkt_count(pc_b));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int dep_of(input int k);  return (k == 0) ? 16 : 8;   endfunction
  function automatic int mar_of(input int k);  return (k == 0) ? 0 : 2;    endfunction
  function automatic int mlen_of(input int k); return (k == 0) ? 1024 : 8; endfunction

  logic [DW+1:0] mf [2][64];
  int            mh [2];
  int            mn [2];
  bit            m_rdy [2], m_inpkt [2], m_drop [2], m_sv [2], m_acc [2], m_err [2], m_tr [2];
  int            m_len [2];
  logic [7:0]    m_seq [2];
  logic [15:0]   m_pc [2];
  logic [31:0]   m_st [2];

  task automatic model_step(input int k);
    bit pop, first, weop, close;
    if (prst) begin
      mn[k] = 0; mh[k] = 0; m_inpkt[k] = 0; m_drop[k] = 0; m_len[k] = 0;
      m_err[k] = 0; m_tr[k] = 0; m_seq[k] = '0; m_pc[k] = '0; m_st[k] = '0;
      m_sv[k] = 0; m_rdy[k] = 0; m_acc[k] = 0;
      return;
    end
    pop      = (mn[k] != 0) && out_ready;
    m_acc[k] = m_rdy[k] && (m_inpkt[k] || m_drop[k] || sop);
    close    = 0;
    if (pop) begin
      mh[k] = (mh[k] + 1) % 64;
      mn[k]--;
    end
    if (m_acc[k]) begin
      if (m_drop[k]) begin
        if (eop) begin close = 1; m_drop[k] = 0; end
      end else begin
        first = !m_inpkt[k];
        if (first) begin
          m_len[k] = 1; m_err[k] = 0; m_tr[k] = 0;
        end else begin
          m_len[k]++;
          if (sop) m_err[k] = 1;
        end
        weop = eop;
        if (eop) begin
          close = 1; m_inpkt[k] = 0;
        end else if (m_len[k] == mlen_of(k)) begin
          weop = 1; m_tr[k] = 1; m_drop[k] = 1; m_inpkt[k] = 0;
        end else begin
          m_inpkt[k] = 1;
        end
        mf[k][(mh[k] + mn[k]) % 64] = {first, weop, data};
        mn[k]++;
      end
    end
    m_sv[k] = close;
    if (close) begin
      m_st[k] = {m_seq[k], 6'b0, m_tr[k], m_err[k], 16'(m_len[k])};
      m_seq[k]++;
      m_pc[k]++;
    end
    m_rdy[k] = m_drop[k] || (mn[k] <= dep_of(k) - 1 - mar_of(k));
  endtask

  task automatic cmp_dut(input int k, input logic r, input logic ov, input logic os,
                         input logic oe, input logic sv, input logic [DW-1:0] od,
                         input logic [SW-1:0] st, input logic [15:0] pc);
    string p;
    logic [DW+1:0] h;
    p = (k == 0) ? "A" : "B";
    h = mf[k][mh[k]];
    chk($sformatf("%s.rdy", p), 64'(r), 64'(m_rdy[k]));
    chk($sformatf("%s.out_valid", p), 64'(ov), 64'(mn[k] != 0));
    if (mn[k] != 0) begin
      chk($sformatf("%s.out_data", p), 64'(od), 64'(h[DW-1:0]));
      chk($sformatf("%s.out_sop", p), 64'(os), 64'(h[DW+1]));
      chk($sformatf("%s.out_eop", p), 64'(oe), 64'(h[DW]));
    end
    chk($sformatf("%s.status_valid", p), 64'(sv), 64'(m_sv[k]));
    chk($sformatf("%s.status", p), 64'(st), 64'({8'h00, m_st[k]}));
    chk($sformatf("%s.pkt_count", p), 64'(pc), 64'(m_pc[k]));
  endtask

  // ---------------- cycle driver ----------------
  logic [DW+1:0] cap_a [$];
  logic [DW+1:0] cap_b [$];
  int            nsv_a, nsv_b;
  logic [31:0]   lst_a, lst_b;

  task automatic tick();
    if (out_ready && ov_a === 1'b1) cap_a.push_back({os_a, oe_a, od_a});
    if (out_ready && ov_b === 1'b1) cap_b.push_back({os_b, oe_b, od_b});
    @(posedge pclk);
    model_step(0);
    model_step(1);
    @(negedge pclk);
    cmp_dut(0, rdy_a, ov_a, os_a, oe_a, sv_a, od_a, st_a, pc_a);
    cmp_dut(1, rdy_b, ov_b, os_b, oe_b, sv_b, od_b, st_b, pc_b);
    if (sv_a === 1'b1) begin nsv_a++; lst_a = st_a[31:0]; end
    if (sv_b === 1'b1) begin nsv_b++; lst_b = st_b[31:0]; end
  endtask

  task automatic clear_obs();
    cap_a.delete(); cap_b.delete();
    nsv_a = 0; nsv_b = 0;
    lst_a = '1;     lst_b = '1;
  endtask

  task automatic do_reset();
    prst = 1'b1; sop = 1'b0; eop = 1'b0;
    tick();
    prst = 1'b0;
    tick();
    clear_obs();
  endtask

  task automatic drive(input int idx, input int n, input int sop_at, input logic [31:0] base);
    if (idx < n) begin
      sop  = (idx == 0) || (idx == sop_at);
      eop  = (idx == n - 1);
      data = DW'(base + 32'(idx));
    end else begin
      sop = 1'b0; eop = 1'b0; data = '0;
    end
  endtask

  // advance on the model's view of acceptance for instance k
  task automatic send_pkt(input int k, input int n, input int sop_at, input logic [31:0] base);
    int idx;
    int g;
    idx = 0; g = 0;
    while (idx < n && g < 400) begin
      drive(idx, n, sop_at, base);
      tick();
      if (m_acc[k]) idx++;
      g++;
    end
    sop = 1'b0; eop = 1'b0;
    chk("send_pkt.beats_taken", 64'(idx), 64'(n));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        prst, sop, eop, ordy;
    logic [31:0] din;
    logic        e_rdy, e_ov, e_sop, e_eop, e_sv;
    logic [31:0] e_dat, e_st;
    logic [15:0] e_pc;
  } vec_t;

  function automatic vec_t mkv(input logic p, input logic s, input logic e, input logic o,
                               input logic [31:0] d, input logic er, input logic ev,
                               input logic es, input logic ee, input logic esv,
                               input logic [31:0] edat, input logic [31:0] est,
                               input logic [15:0] epc);
    vec_t v;
    v.prst = p; v.sop = s; v.eop = e; v.ordy = o; v.din = d;
    v.e_rdy = er; v.e_ov = ev; v.e_sop = es; v.e_eop = ee; v.e_sv = esv;
    v.e_dat = edat; v.e_st = est; v.e_pc = epc;
    return v;
  endfunction

  vec_t tbl [11];

  initial begin
    int nacc, idx, nsop, neop;
    logic [31:0] base;

    tbl[0]  = mkv(0,0,0,1, 32'h0,  1,0,0,0,0, 32'h0,  32'h0000_0000, 16'd0);
    tbl[1]  = mkv(0,1,0,1, 32'hA0, 1,1,1,0,0, 32'hA0, 32'h0000_0000, 16'd0);
    tbl[2]  = mkv(0,0,0,1, 32'hA1, 1,1,0,0,0, 32'hA1, 32'h0000_0000, 16'd0);
    tbl[3]  = mkv(0,0,0,1, 32'hA2, 1,1,0,0,0, 32'hA2, 32'h0000_0000, 16'd0);
    tbl[4]  = mkv(0,0,1,1, 32'hA3, 1,1,0,1,1, 32'hA3, 32'h0000_0004, 16'd1);
    tbl[5]  = mkv(0,0,0,1, 32'h0,  1,0,0,0,0, 32'h0,  32'h0000_0004, 16'd1);
    tbl[6]  = mkv(1,0,0,1, 32'h0,  0,0,0,0,0, 32'h0,  32'h0000_0000, 16'd0);
    tbl[7]  = mkv(0,0,0,1, 32'h0,  1,0,0,0,0, 32'h0,  32'h0000_0000, 16'd0);
    tbl[8]  = mkv(0,1,1,1, 32'hB0, 1,1,1,1,1, 32'hB0, 32'h0000_0001, 16'd1);
    tbl[9]  = mkv(0,1,1,1, 32'hB1, 1,1,1,1,1, 32'hB1, 32'h0100_0001, 16'd2);
    tbl[10] = mkv(0,0,0,1, 32'h0,  1,0,0,0,0, 32'h0,  32'h0100_0001, 16'd2);

    prst = 1'b1; sop = 1'b0; eop = 1'b0; data = '0; out_ready = 1'b1;
    clear_obs();
    tick();
    tick();
    chk("reset.rdy", 64'(rdy_a), 64'd0);
    chk("reset.status", 64'(st_a), 64'd0);

    // 4-beat packet, reset, then two single-beat packets
    for (int i = 0; i < 11; i++) begin
      prst = tbl[i].prst; sop = tbl[i].sop; eop = tbl[i].eop;
      out_ready = tbl[i].ordy; data = tbl[i].din;
      tick();
      chk($sformatf("vec%0d.rdy", i), 64'(rdy_a), 64'(tbl[i].e_rdy));
      chk($sformatf("vec%0d.out_valid", i), 64'(ov_a), 64'(tbl[i].e_ov));
      if (tbl[i].e_ov) begin
        chk($sformatf("vec%0d.out_sop", i), 64'(os_a), 64'(tbl[i].e_sop));
        chk($sformatf("vec%0d.out_eop", i), 64'(oe_a), 64'(tbl[i].e_eop));
        chk($sformatf("vec%0d.out_data", i), 64'(od_a), 64'(tbl[i].e_dat));
      end
      chk($sformatf("vec%0d.status_valid", i), 64'(sv_a), 64'(tbl[i].e_sv));
      chk($sformatf("vec%0d.status", i), 64'(st_a), 64'(tbl[i].e_st));
      chk($sformatf("vec%0d.pkt_count", i), 64'(pc_a), 64'(tbl[i].e_pc));
    end
    sop = 1'b0; eop = 1'b0;

    // FIFO fill: 20-beat packet into a 16-deep FIFO with the sink stalled
    do_reset();
    base = 32'h0001_0000;
    out_ready = 1'b0; idx = 0; nacc = 0;
    for (int c = 0; c < 30; c++) begin
      bit adv;
      drive(idx, 20, -1, base);
      adv = (rdy_a === 1'b1) && (idx < 20);
      if (adv) nacc++;
      tick();
      if (adv) idx++;
    end
    chk("fill.accepted", 64'(nacc), 64'd16);
    chk("fill.rdy_low", 64'(rdy_a), 64'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 80; c++) begin
      bit adv;
      drive(idx, 20, -1, base);
      adv = (rdy_a === 1'b1) && (idx < 20);
      tick();
      if (adv) idx++;
    end
    chk("fill.out_beats", 64'(cap_a.size()), 64'd20);
    for (int i = 0; i < cap_a.size() && i < 20; i++) begin
      logic [DW+1:0] e;
      e = cap_a[i];
      chk($sformatf("fill.beat%0d", i), 64'(e), 64'({(i == 0), (i == 19), DW'(base + 32'(i))}));
    end
    chk("fill.status", 64'(lst_a), 64'h0000_0014);
    chk("fill.status_pulses", 64'(nsv_a), 64'd1);

    // truncation on the MAX_LEN=8 instance: 12-beat packet
    do_reset();
    base = 32'h0002_0000;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(i, 12, -1, base);
      chk($sformatf("trunc.rdy_beat%0d", i), 64'(rdy_b), 64'd1);
      if (i == 11) chk("trunc.no_early_status", 64'(nsv_b), 64'd0);
      tick();
    end
    sop = 1'b0; eop = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    chk("trunc.out_beats", 64'(cap_b.size()), 64'd8);
    neop = 0;
    foreach (cap_b[i]) begin
      logic [DW+1:0] e;
      e = cap_b[i];
      if (e[DW]) neop++;
    end
    chk("trunc.eop_count", 64'(neop), 64'd1);
    if (cap_b.size() == 8) begin
      logic [DW+1:0] e;
      e = cap_b[7];
      chk("trunc.last_eop", 64'(e[DW]), 64'd1);
      chk("trunc.last_data", 64'(e[DW-1:0]), 64'(base + 32'd7));
    end
    chk("trunc.status", 64'(lst_b), 64'h0002_0008);
    chk("trunc.status_pulses", 64'(nsv_b), 64'd1);

    // stray sop on beat 3 of a 5-beat packet
    do_reset();
    base = 32'h0003_0000;
    out_ready = 1'b1;
    send_pkt(0, 5, 2, base);
    for (int c = 0; c < 4; c++) tick();
    chk("errsop.out_beats", 64'(cap_a.size()), 64'd5);
    nsop = 0; neop = 0;
    foreach (cap_a[i]) begin
      logic [DW+1:0] e;
      e = cap_a[i];
      if (e[DW+1]) nsop++;
      if (e[DW])   neop++;
    end
    chk("errsop.sop_count", 64'(nsop), 64'd1);
    chk("errsop.eop_count", 64'(neop), 64'd1);
    chk("errsop.status", 64'(lst_a), 64'h0001_0005);

    // reset in the middle of a packet with data in the FIFO
    do_reset();
    base = 32'h0004_0000;
    out_ready = 1'b1;
    send_pkt(0, 1, -1, base);
    tick(); tick();
    chk("midrst.pre_count", 64'(pc_a), 64'd1);
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(i, 6, -1, base + 32'h100);
      tick();
    end
    chk("midrst.fifo_nonempty", 64'(ov_a), 64'd1);
    prst = 1'b1;
    drive(2, 6, -1, base + 32'h100);
    tick();
    chk("midrst.out_valid", 64'(ov_a), 64'd0);
    chk("midrst.rdy", 64'(rdy_a), 64'd0);
    chk("midrst.status_valid", 64'(sv_a), 64'd0);
    prst = 1'b0; sop = 1'b0; eop = 1'b0;
    tick();
    chk("midrst.rdy_after", 64'(rdy_a), 64'd1);
    chk("midrst.status_valid_after", 64'(sv_a), 64'd0);
    clear_obs();
    out_ready = 1'b1;
    send_pkt(0, 3, -1, base + 32'h200);
    for (int c = 0; c < 3; c++) tick();
    chk("midrst.next_status", 64'(lst_a), 64'h0000_0003);
    chk("midrst.next_count", 64'(pc_a), 64'd1);
    chk("midrst.pulses", 64'(nsv_a), 64'd1);

    // random traffic, both instances checked against the model every cycle
    for (int c = 0; c < 3000; c++) begin
      prst      = ($urandom_range(0, 399) == 0);
      sop       = ($urandom_range(0, 99) < 35);
      eop       = ($urandom_range(0, 99) < 30);
      data      = DW'($urandom);
      out_ready = ($urandom_range(0, 99) < 70);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pkt_rx_responder.md
Name: pkt_rx_responder

Overview:
- Parametrised packet-bus responder. Accepts sop/eop/data beats, throttles the sender with rdy, buffers beats in a first-word-fall-through FIFO and forwards them to a downstream ready/valid port.
- For every closed packet it returns a per-packet status word: length, error flags and sequence number.
- Sits on the DUT/agent boundary wherever the pkt bus is terminated.

Parameters:
- DATA_WIDTH, 240, width of data and out_data.
- STATUS_WIDTH, 32, width of status; minimum 32; bits above 31 are driven 0.
- FIFO_DEPTH, 16, beat buffer entries; power of 2, minimum 4.
- FULL_MARGIN, 0, extra free entries held in reserve before rdy drops; 0 to FIFO_DEPTH-2.
- MAX_LEN, 1024, maximum beats per packet; 1 to 65535.

Ports:
- pclk  input  1  clock, all logic on rising edge.
- prst  input  1  reset, synchronous, active-high.
- sop  input  1  start of packet, qualified by rdy.
- eop  input  1  end of packet, qualified by rdy.
- data  input  DATA_WIDTH  beat payload.
- rdy  output  1  responder can take a beat this cycle.
- status  output  STATUS_WIDTH  status of the most recently closed packet.
- status_valid  output  1  one-cycle pulse, status updated.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  downstream pops the head.
- out_data  output  DATA_WIDTH  head payload.
- out_sop  output  1  head is first beat of a packet.
- out_eop  output  1  head is last beat of a packet.
- pkt_count  output  16  packets closed since reset; wraps.

Behaviour:
- Reset: synchronous on prst=1.
  - Outputs during reset: rdy=0, status=0, status_valid=0, out_valid=0, pkt_count=0.
  - FIFO flushed, FSM to IDLE, 8-bit seq=0, beat counter=0.
  - A packet in flight when prst asserts is discarded with no status.
  - rdy=1 in the first cycle after prst deasserts.
- Beat transfer: a cycle with rdy=1 and either (state IDLE and sop=1) or (state PKT/DROP).
  - Input values while rdy=0 are ignored.
- FSM states: IDLE, PKT, DROP.
  - IDLE, sop: if eop is also 1, write a single-beat packet (out_sop=out_eop=1), close it, stay IDLE. Otherwise write the beat with out_sop=1, len=1, go to PKT.
  - IDLE, eop without sop: ignored, nothing written.
  - PKT, each beat: write it, len+1.
  - PKT, sop=1 on a non-first beat: treated as data (written with out_sop=0) and sets err_sop for this packet.
  - PKT, eop: write with out_eop=1, close the packet, go to IDLE.
  - PKT, overlength: if len reaches MAX_LEN on a beat without eop, that beat is written with out_eop=1, trunc is set and the state goes to DROP.
  - DROP: beats are discarded, no FIFO writes, rdy forced 1. On eop, close the packet and go to IDLE.
- Packet close, registered, asserted at t+1 where t is the closing beat:
  - status[15:0]=beats written.
  - status[16]=err_sop.
  - status[17]=trunc.
  - status[23:18]=0.
  - status[31:24]=seq.
  - status_valid=1 for one cycle.
  - seq wraps 255->0; pkt_count wraps 65535->0.
  - status holds its value until the next close.
- rdy (registered): rdy <= (count_next <= FIFO_DEPTH-1-FULL_MARGIN), except forced 1 in DROP.
  - count_next is the occupancy after this cycle's push/pop.
  - This rule guarantees no overflow.
- FIFO:
  - A write at t is visible on out_* at t+1.
  - out_valid = count != 0.
  - Pop when out_valid & out_ready.
  - Simultaneous push and pop leaves count unchanged, including at full and when count=1.
  - Pop when empty has no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- Close and new sop in the same cycle cannot occur. The only close-on-sop case is IDLE with sop&eop, which is a single beat.

Test Plan:
- 4-beat packet (sop@t0, eop@t3), out_ready=1 -> out beats at t1..t4 (out_sop at t1, out_eop at t4); status_valid@t4 with status=0x0000_0004 (seq 0); pkt_count=1.
- Single-beat packet (sop&eop) sent twice -> each has out_sop=out_eop=1; status 0x0000_0001 then 0x0100_0001.
- FIFO_DEPTH=16, FULL_MARGIN=0, out_ready=0, 20-beat packet -> exactly 16 beats accepted, then rdy=0. Raising out_ready drains all 20 in order with no loss or duplication; status length 20.
- MAX_LEN=8, 12-beat packet -> 8 beats out, 8th with out_eop. Beats 9-12 accepted with rdy=1 but discarded. status=0x0002_0008 after the input eop.
- 5-beat packet with sop also asserted on beat 3 -> 5 beats out, exactly one out_sop and one out_eop, status[16]=1, length 5.
- prst for 1 cycle at beat 2 of a 6-beat packet with the FIFO non-empty -> out_valid=0, rdy=0 during reset, no status_valid. The next packet reports seq 0 and pkt_count becomes 1.
